pipe_hazard_ctrl: RTL and testbench

Hazard and stall controller for the 5-stage MIPS pipeline. It generates the stall and flush controls for the IF/ID and ID/EX pipeline registers. It also produces the E-stage and D-stage forwarding selects and sequences a multi-cycle multiply/divide unit through a busy FSM. A saturating stall-cycle counter is provided for performance debug.

---
 rtl/pipe_hazard_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall controller for a classic 5-stage MIPS pipeline.
// It produces the stall and flush controls for the IF/ID and ID/EX registers
// and the D/E-stage forwarding selects. It also sequences the multi-cycle
// multiply/divide unit and keeps a saturating stall-cycle counter for
// performance debug.
module pipe_hazard_ctrl #(
  parameter int MD_LAT = 4,   // mult/div latency in cycles, 1..8 (3-bit down-counter)
  parameter int CNT_W  = 16   // stall-cycle counter width
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [4:0]       i_rsD,
  input  logic [4:0]       i_rtD,
  input  logic [4:0]       i_rsE,
  input  logic [4:0]       i_rtE,
  input  logic [4:0]       i_writeregE,
  input  logic [4:0]       i_writeregM,
  input  logic [4:0]       i_writeregW,
  input  logic             i_regwriteE,
  input  logic             i_regwriteM,
  input  logic             i_regwriteW,
  input  logic             i_memtoregE,
  input  logic             i_memtoregM,
  input  logic             i_branchD,
  input  logic             i_pcsrcD,
  input  logic             i_jumpD,
  input  logic             i_mdopD,
  input  logic             i_mdstartE,
  input  logic             i_imem_ready,
  output logic             o_stallF,
  output logic             o_stallD,
  output logic             o_flushD,
  output logic             o_flushE,
  output logic             o_fwdAD,
  output logic             o_fwdBD,
  output logic [1:0]       o_fwdAE,
  output logic [1:0]       o_fwdBE,
  output logic             o_md_busy,
  output logic [CNT_W-1:0] o_stall_cnt
);

  // Forwarding select encodings for the E-stage ALU operand muxes.
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // Busy lasts MD_LAT cycles: the counter runs MD_LAT-1 down to 0 inclusive.
  localparam logic [2:0] MD_LOAD = 3'(MD_LAT - 1);

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  md_state_t  md_state;
  logic [2:0] mdcnt;

  logic lwstall;
  logic brstall;
  logic mdstall;
  logic imiss;
  logic stall;

  // A producer matches a consumer only when it writes a register other
  // than $0; $0 is hardwired to zero and never needs forwarding or stalls.
  function automatic logic reg_hit(input logic       we,
                                   input logic [4:0] wr,
                                   input logic [4:0] src);
    return we && (wr != 5'd0) && (wr == src);
  endfunction

  // E-stage operand select: the younger M result wins over the W result.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (reg_hit(i_regwriteM, i_writeregM, src))
      return FWD_M;
    else if (reg_hit(i_regwriteW, i_writeregW, src))
      return FWD_W;
    else
      return FWD_RF;
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v)
      return v;
    else
      return v + 1'b1;
  endfunction

  // Hazard detection: each term is one reason the front end must hold.
  always_comb begin
    lwstall = i_memtoregE &&
              (reg_hit(i_regwriteE, i_writeregE, i_rsD) ||
               reg_hit(i_regwriteE, i_writeregE, i_rtD));
    brstall = i_branchD &&
              (reg_hit(i_regwriteE, i_writeregE, i_rsD) ||
               reg_hit(i_regwriteE, i_writeregE, i_rtD) ||
               reg_hit(i_memtoregM, i_writeregM, i_rsD) ||
               reg_hit(i_memtoregM, i_writeregM, i_rtD));
    mdstall = o_md_busy && i_mdopD;
    imiss   = !i_imem_ready;
    stall   = lwstall || brstall || mdstall || imiss;
  end

  // Stall/flush/forward outputs; reset forces bubbles and a cleared IF/ID.
  always_comb begin
    o_stallF = 1'b0;
    o_stallD = 1'b0;
    o_flushD = 1'b1;
    o_flushE = 1'b1;
    o_fwdAD  = 1'b0;
    o_fwdBD  = 1'b0;
    o_fwdAE  = FWD_RF;
    o_fwdBE  = FWD_RF;
    if (!i_rst) begin
      o_stallF = stall;
      o_stallD = stall;
      o_flushE = stall;
      // A held IF/ID keeps its instruction; a redirect is only taken once
      // the stall clears.
      o_flushD = (i_pcsrcD || i_jumpD) && !stall;
      o_fwdAD  = reg_hit(i_regwriteM, i_writeregM, i_rsD);
      o_fwdBD  = reg_hit(i_regwriteM, i_writeregM, i_rtD);
      o_fwdAE  = fwd_sel(i_rsE);
      o_fwdBE  = fwd_sel(i_rtE);
    end
  end

  // Mult/div sequencer: busy is registered and held for MD_LAT cycles.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      md_state  <= MD_IDLE;
      mdcnt     <= 3'd0;
      o_md_busy <= 1'b0;
    end else begin
      case (md_state)
        MD_IDLE: begin
          if (i_mdstartE) begin
            md_state  <= MD_BUSY;
            mdcnt     <= MD_LOAD;
            o_md_busy <= 1'b1;
          end
        end
        MD_BUSY: begin
          // A start while busy is ignored: the running operation keeps
          // its original countdown.
          if (mdcnt == 3'd0) begin
            md_state  <= MD_IDLE;
            o_md_busy <= 1'b0;
          end else begin
            mdcnt <= mdcnt - 3'd1;
          end
        end
        default: begin
          md_state  <= MD_IDLE;
          mdcnt     <= 3'd0;
          o_md_busy <= 1'b0;
        end
      endcase
    end
  end

  // Performance counter: one count per stalled cycle, saturating.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      o_stall_cnt <= '0;
    else if (stall)
      o_stall_cnt <= sat_inc(o_stall_cnt);
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: forwarding, load-use, branch,
// mult/div busy sequencing, instruction-miss hold, reset and saturation.
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] rsD, rtD, rsE, rtE;
  logic [4:0] wrE, wrM, wrW;
  logic       rwE, rwM, rwW;
  logic       m2rE, m2rM;
  logic       branchD, pcsrcD, jumpD, mdopD, mdstartE, imem_ready;

  logic        stallF, stallD, flushD, flushE, fwdAD, fwdBD, md_busy;
  logic [1:0]  fwdAE, fwdBE;
  logic [15:0] stall_cnt;

  logic        s_stallF, s_stallD, s_flushD, s_flushE, s_fwdAD, s_fwdBD, s_md_busy;
  logic [1:0]  s_fwdAE, s_fwdBE;
  logic [1:0]  s_stall_cnt;

  int ncmp = 0;
  int nerr = 0;

  pipe_hazard_ctrl #(.MD_LAT(4), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_rsD(rsD), .i_rtD(rtD), .i_rsE(rsE), .i_rtE(rtE),
    .i_writeregE(wrE), .i_writeregM(wrM), .i_writeregW(wrW),
    .i_regwriteE(rwE), .i_regwriteM(rwM), .i_regwriteW(rwW),
    .i_memtoregE(m2rE), .i_memtoregM(m2rM),
    .i_branchD(branchD), .i_pcsrcD(pcsrcD), .i_jumpD(jumpD),
    .i_mdopD(mdopD), .i_mdstartE(mdstartE), .i_imem_ready(imem_ready),
    .o_stallF(stallF), .o_stallD(stallD), .o_flushD(flushD), .o_flushE(flushE),
    .o_fwdAD(fwdAD), .o_fwdBD(fwdBD), .o_fwdAE(fwdAE), .o_fwdBE(fwdBE),
    .o_md_busy(md_busy), .o_stall_cnt(stall_cnt)
  );

  pipe_hazard_ctrl #(.MD_LAT(4), .CNT_W(2)) dut_sat (
    .i_clk(clk), .i_rst(rst),
    .i_rsD(rsD), .i_rtD(rtD), .i_rsE(rsE), .i_rtE(rtE),
    .i_writeregE(wrE), .i_writeregM(wrM), .i_writeregW(wrW),
    .i_regwriteE(rwE), .i_regwriteM(rwM), .i_regwriteW(rwW),
    .i_memtoregE(m2rE), .i_memtoregM(m2rM),
    .i_branchD(branchD), .i_pcsrcD(pcsrcD), .i_jumpD(jumpD),
    .i_mdopD(mdopD), .i_mdstartE(mdstartE), .i_imem_ready(imem_ready),
    .o_stallF(s_stallF), .o_stallD(s_stallD), .o_flushD(s_flushD), .o_flushE(s_flushE),
    .o_fwdAD(s_fwdAD), .o_fwdBD(s_fwdBD), .o_fwdAE(s_fwdAE), .o_fwdBE(s_fwdBE),
    .o_md_busy(s_md_busy), .o_stall_cnt(s_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    rsD = 5'd0; rtD = 5'd0; rsE = 5'd0; rtE = 5'd0;
    wrE = 5'd0; wrM = 5'd0; wrW = 5'd0;
    rwE = 1'b0; rwM = 1'b0; rwW = 1'b0;
    m2rE = 1'b0; m2rM = 1'b0;
    branchD = 1'b0; pcsrcD = 1'b0; jumpD = 1'b0;
    mdopD = 1'b0; mdstartE = 1'b0; imem_ready = 1'b1;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    // Hazards present during reset must be masked.
    rwM = 1'b1; wrM = 5'd3; rsE = 5'd3; imem_ready = 1'b0;
    tick();
    tick();
    check("rst_stallF", stallF, 1'b0);
    check("rst_stallD", stallD, 1'b0);
    check("rst_flushD", flushD, 1'b1);
    check("rst_flushE", flushE, 1'b1);
    check("rst_fwdAE", fwdAE, 2'b00);
    check("rst_busy", md_busy, 1'b0);
    check("rst_cnt", stall_cnt, 16'd0);

    // Forwarding
    rst = 1'b0;
    idle_inputs();
    rwM = 1'b1; wrM = 5'd3; rwW = 1'b1; wrW = 5'd3; rsE = 5'd3;
    #1;
    check("fwdAE_M", fwdAE, 2'b10);
    check("fwdBE_none", fwdBE, 2'b00);
    check("fwd_nostall", stallD, 1'b0);
    rwM = 1'b0; rtE = 5'd3;
    #1;
    check("fwdAE_W", fwdAE, 2'b01);
    check("fwdBE_W", fwdBE, 2'b01);
    rwM = 1'b1; wrM = 5'd0; wrW = 5'd0; rsE = 5'd0; rtE = 5'd0;
    #1;
    check("fwdAE_r0", fwdAE, 2'b00);
    check("fwdBE_r0", fwdBE, 2'b00);

    // Load-use
    tick();
    check("cnt_pre_lw", stall_cnt, 16'd0);
    idle_inputs();
    m2rE = 1'b1; rwE = 1'b1; wrE = 5'd0;
    #1;
    check("lw_r0_nostall", stallD, 1'b0);
    wrE = 5'd5; rtD = 5'd5;
    #1;
    check("lw_stallF", stallF, 1'b1);
    check("lw_stallD", stallD, 1'b1);
    check("lw_flushE", flushE, 1'b1);
    tick();
    idle_inputs();
    #1;
    check("lw_release", stallD, 1'b0);
    check("lw_cnt", stall_cnt, 16'd1);
    check("lw_cnt_sat", s_stall_cnt, 2'd1);

    // Branch dependent on an E-stage result, then forwarded from M
    branchD = 1'b1; pcsrcD = 1'b1; rsD = 5'd7; rwE = 1'b1; wrE = 5'd7;
    #1;
    check("br_stall", stallD, 1'b1);
    check("br_flushD_held", flushD, 1'b0);
    tick();
    rwE = 1'b0; wrE = 5'd0; rwM = 1'b1; wrM = 5'd7;
    #1;
    check("br_fwdAD", fwdAD, 1'b1);
    check("br_fwdBD", fwdBD, 1'b0);
    check("br_nostall", stallD, 1'b0);
    check("br_flushD", flushD, 1'b1);
    check("br_cnt", stall_cnt, 16'd2);
    check("br_cnt_sat", s_stall_cnt, 2'd2);

    // Mult/div busy sequencing
    tick();
    idle_inputs();
    mdstartE = 1'b1;
    tick();                                   // P1: busy 1st cycle
    mdstartE = 1'b0;
    check("md_busy1", md_busy, 1'b1);
    mdopD = 1'b1;
    #1;
    check("md_stall1", stallD, 1'b1);
    tick();                                   // P2
    check("md_busy2", md_busy, 1'b1);
    mdstartE = 1'b1;                          // illegal start while busy: ignored
    tick();                                   // P3
    mdstartE = 1'b0;
    check("md_busy3", md_busy, 1'b1);
    check("md_stall3", stallD, 1'b1);
    tick();                                   // P4
    check("md_busy4", md_busy, 1'b1);
    tick();                                   // P5: busy drops
    check("md_busy_drop", md_busy, 1'b0);
    check("md_release", stallD, 1'b0);
    check("md_cnt", stall_cnt, 16'd6);
    check("md_cnt_sat", s_stall_cnt, 2'd3);
    mdopD = 1'b0;

    // Instruction-memory miss with a pending taken branch
    imem_ready = 1'b0; pcsrcD = 1'b1;
    #1;
    check("im_stall0", stallD, 1'b1);
    check("im_flushD0", flushD, 1'b0);
    tick();
    check("im_stall1", stallD, 1'b1);
    tick();
    check("im_flushD2", flushD, 1'b0);
    tick();
    imem_ready = 1'b1;
    #1;
    check("im_release", stallD, 1'b0);
    check("im_flushD", flushD, 1'b1);
    check("im_cnt", stall_cnt, 16'd9);
    check("im_cnt_sat", s_stall_cnt, 2'd3);

    // Reset in the second busy cycle
    tick();
    idle_inputs();
    mdstartE = 1'b1;
    tick();                                   // 1st busy cycle
    mdstartE = 1'b0;
    tick();                                   // 2nd busy cycle
    check("rb_busy", md_busy, 1'b1);
    rst = 1'b1; imem_ready = 1'b0;
    #1;
    check("rb_flushD", flushD, 1'b1);
    check("rb_flushE", flushE, 1'b1);
    check("rb_stallD", stallD, 1'b0);
    tick();
    check("rb_busy_clr", md_busy, 1'b0);
    check("rb_cnt", stall_cnt, 16'd0);
    check("rb_cnt_sat", s_stall_cnt, 2'd0);
    rst = 1'b0; imem_ready = 1'b1;
    tick();
    check("rb_busy_stays", md_busy, 1'b0);
    check("rb_cnt_stays", stall_cnt, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
